seven_seg_scan_ctrl: RTL

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seven_seg_scan_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_ctrl
// Description : Time-multiplexed scan controller for a DIGITS-wide common-
//               anode seven-segment display.  Double-buffered data (shadow ->
//               active at frame boundaries), hex decode, per-digit blanking,
//               leading-zero suppression and PWM brightness on the anodes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i    in   1          clock, rising edge
//   rst_i    in   1          asynchronous active-high reset
//   value_i  in   4*DIGITS   hex nibbles, nibble k drives digit k (0 = right)
//   dp_i     in   DIGITS     decimal point request per digit, 1 = lit
//   blank_i  in   DIGITS     forced blank per digit, 1 = dark
//   lzs_i    in   1          leading-zero suppression enable
//   load_i   in   1          strobe capturing value/dp/blank/lzs
//   bright_i in   4          brightness, 0 = 1/16 duty, 15 = full slot
//   an_o     out  DIGITS     active-low anodes
//   seg_o    out  7          active-low cathodes {a,b,c,d,e,f,g}
//   dp_o     out  1          active-low decimal point cathode
//   frame_o  out  1          one-cycle pulse after each frame boundary
// ============================================================================
module seven_seg_scan_ctrl #(
   parameter int DIGITS = 8,   // 2..16
   parameter int DIV_W  = 17   // >= 4; slot length is 2^DIV_W cycles
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [4*DIGITS-1:0]   value_i,
   input  logic [DIGITS-1:0]     dp_i,
   input  logic [DIGITS-1:0]     blank_i,
   input  logic                  lzs_i,
   input  logic                  load_i,
   input  logic [3:0]            bright_i,
   output logic [DIGITS-1:0]     an_o,
   output logic [6:0]            seg_o,
   output logic                  dp_o,
   output logic                  frame_o
);

   localparam int               IDX_W    = $clog2(DIGITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   logic [DIV_W-1:0]    slot_cnt;
   logic [IDX_W-1:0]    idx;
   logic                slot_tick;
   logic                frame_bnd;

   logic [4*DIGITS-1:0] sh_value, act_value;
   logic [DIGITS-1:0]   sh_dp, act_dp;
   logic [DIGITS-1:0]   sh_blank, act_blank;
   logic                sh_lzs, act_lzs;
   logic                pending;

   logic [3:0]          nib [DIGITS];
   logic [3:0]          cur_nib;
   logic                upper_nonzero;
   logic                dark;
   logic                an_on;
   logic [DIGITS-1:0]   an_d;
   logic [6:0]          seg_d;
   logic                dp_d;

   assign slot_tick = &slot_cnt;
   assign frame_bnd = slot_tick && (idx == '0);

   // ------------------------------------------------------------------
   // Scan timing: slot counter and descending digit index
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         slot_cnt <= '0;
         idx      <= LAST_IDX;
      end else begin
         slot_cnt <= slot_cnt + 1'b1;
         if (slot_tick)
            idx <= (idx == '0) ? LAST_IDX : idx - 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Double buffer.  A load landing exactly on a boundary bypasses the
   // shadow so it is not delayed by a whole frame.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sh_value  <= '0;
         sh_dp     <= '0;
         sh_blank  <= '1;
         sh_lzs    <= 1'b0;
         act_value <= '0;
         act_dp    <= '0;
         act_blank <= '1;
         act_lzs   <= 1'b0;
         pending   <= 1'b0;
      end else if (load_i && frame_bnd) begin
         sh_value  <= value_i;
         sh_dp     <= dp_i;
         sh_blank  <= blank_i;
         sh_lzs    <= lzs_i;
         act_value <= value_i;
         act_dp    <= dp_i;
         act_blank <= blank_i;
         act_lzs   <= lzs_i;
         pending   <= 1'b0;
      end else if (load_i) begin
         sh_value  <= value_i;
         sh_dp     <= dp_i;
         sh_blank  <= blank_i;
         sh_lzs    <= lzs_i;
         pending   <= 1'b1;
      end else if (frame_bnd && pending) begin
         act_value <= sh_value;
         act_dp    <= sh_dp;
         act_blank <= sh_blank;
         act_lzs   <= sh_lzs;
         pending   <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Digit data path
   // ------------------------------------------------------------------
   for (genvar k = 0; k < DIGITS; k++) begin : g_nib
      assign nib[k] = act_value[4*k +: 4];
   end

   assign cur_nib = nib[idx];

   // Any non-zero nibble at or above the current digit defeats suppression.
   always_comb begin
      upper_nonzero = 1'b0;
      for (int j = 0; j < DIGITS; j++) begin
         if ((j >= int'(idx)) && (nib[j] != 4'h0))
            upper_nonzero = 1'b1;
      end
   end

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b0000001;
         4'h1: hex7 = 7'b1001111;
         4'h2: hex7 = 7'b0010010;
         4'h3: hex7 = 7'b0000110;
         4'h4: hex7 = 7'b1001100;
         4'h5: hex7 = 7'b0100100;
         4'h6: hex7 = 7'b0100000;
         4'h7: hex7 = 7'b0001111;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0000100;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b1100000;
         4'hC: hex7 = 7'b0110001;
         4'hD: hex7 = 7'b1000010;
         4'hE: hex7 = 7'b0110000;
         default: hex7 = 7'b0111000;
      endcase
   endfunction

   // A dark digit keeps its anode off as well, so cathodes and anodes are
   // only ever active together (no ghosting across digit changes).
   always_comb begin
      dark  = act_blank[idx] || (act_lzs && (idx != '0) && !upper_nonzero);
      an_on = !dark && (slot_cnt[DIV_W-1 -: 4] <= bright_i);
      an_d  = '1;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (an_on) begin
         an_d[idx] = 1'b0;
         seg_d     = hex7(cur_nib);
         dp_d      = ~act_dp[idx];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         an_o    <= '1;
         seg_o   <= 7'h7F;
         dp_o    <= 1'b1;
         frame_o <= 1'b0;
      end else begin
         an_o    <= an_d;
         seg_o   <= seg_d;
         dp_o    <= dp_d;
         frame_o <= frame_bnd;
      end
   end

endmodule
`default_nettype wire
